// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker: compares each accepted sample against the previous one, tracks the
// running max/min and saturating rise/fall/equal counts, and presents every result
// through a single-entry valid/ready output buffer.
// Optional build macro CMP_SIGNED_EN: compare samples as two's complement instead of unsigned.
module cmp_stream_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cmp_eq,
  output logic             cmp_gt,
  output logic             cmp_lt,
  output logic             first,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  typedef enum logic {StEmpty, StRun} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, max_q, max_d, min_q, min_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d, first_q, first_d, valid_q, valid_d;
  logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d, eqc_q, eqc_d;
  logic             accept;

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CntMax) ? c : c + 1'b1;
  endfunction

  // A held result blocks new samples; clear also blocks so its sample is never taken.
  assign in_ready = (!valid_q || out_ready) && !clear;
  assign accept   = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: any accept leaves the block in RUN; clear returns to EMPTY.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StRun;
    end
  end

  // Result and history next values for the current state and handshake.
  always_comb begin
    prev_d  = prev_q;
    max_d   = max_q;
    min_d   = min_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    first_d = first_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    eqc_d   = eqc_q;
    valid_d = valid_q;
    if (clear) begin
      prev_d  = '0;
      max_d   = '0;
      min_d   = '0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
      first_d = 1'b0;
      rise_d  = '0;
      fall_d  = '0;
      eqc_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      prev_d  = in_data;
      unique case (state_q)
        StEmpty: begin
          max_d   = in_data;
          min_d   = in_data;
          first_d = 1'b1;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end
        StRun: begin
          first_d = 1'b0;
          gt_d    = greater(in_data, prev_q);
          lt_d    = greater(prev_q, in_data);
          eq_d    = (in_data == prev_q);
          if (greater(in_data, max_q)) max_d = in_data;
          if (greater(min_q, in_data)) min_d = in_data;
          if (gt_d) rise_d = sat_inc(rise_q);
          if (lt_d) fall_d = sat_inc(fall_q);
          if (eq_d) eqc_d = sat_inc(eqc_q);
        end
        default: ;
      endcase
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers; a reset drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      max_q   <= '0;
      min_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      first_q <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
      eqc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      max_q   <= max_d;
      min_q   <= min_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      first_q <= first_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      eqc_q   <= eqc_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign cmp_eq    = eq_q;
  assign cmp_gt    = gt_q;
  assign cmp_lt    = lt_q;
  assign first     = first_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign rise_cnt  = rise_q;
  assign fall_cnt  = fall_q;
  assign eq_cnt    = eqc_q;

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Bench for cmp_stream_tracker: directed table, corner sequences and a random stream
// checked against a sample-history model. A second instance with CNT_W=2 shares all inputs.
module tb_cmp_stream_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, out_valid, cmp_eq, cmp_gt, cmp_lt, first;
  logic [3:0] max_val, min_val;
  logic [7:0] rise_cnt, fall_cnt, eq_cnt;
  logic       s_in_ready, s_out_valid, s_eq, s_gt, s_lt, s_first;
  logic [3:0] s_max, s_min;
  logic [1:0] s_rise, s_fall, s_eqc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .cmp_eq(cmp_eq),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .first(first), .max_val(max_val), .min_val(min_val),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .eq_cnt(eq_cnt)
  );

  cmp_stream_tracker #(.WIDTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .cmp_eq(s_eq),
    .cmp_gt(s_gt), .cmp_lt(s_lt), .first(s_first), .max_val(s_max), .min_val(s_min),
    .rise_cnt(s_rise), .fall_cnt(s_fall), .eq_cnt(s_eqc)
  );

  // Model: the list of samples accepted since reset/clear plus event totals.
  logic [3:0] hist[$];
  logic       m_valid;
  int         m_rise, m_fall, m_eq;

  function automatic int val(input logic [3:0] x);
`ifdef CMP_SIGNED_EN
    return int'($signed(x));
`else
    return int'({28'd0, x});
`endif
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(input int c, input int lim);
    return (c > lim) ? lim : c;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_valid = 1'b0;
    m_rise = 0;
    m_fall = 0;
    m_eq = 0;
  endfunction

  function automatic void model_step(input logic cl, input logic acc, input logic [3:0] d,
                                     input logic ordy);
    if (cl) begin
      model_reset();
    end else if (acc) begin
      if (hist.size() > 0) begin
        if (val(d) > val(hist[$])) m_rise++;
        else if (val(d) < val(hist[$])) m_fall++;
        else m_eq++;
      end
      hist.push_back(d);
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endfunction

  function automatic void check_model();
    logic [3:0] mx, mn;
    logic [2:0] fl;
    mx = '0;
    mn = '0;
    fl = 3'b000;
    if (hist.size() > 0) begin
      mx = hist[0];
      mn = hist[0];
      foreach (hist[i]) begin
        if (val(hist[i]) > val(mx)) mx = hist[i];
        if (val(hist[i]) < val(mn)) mn = hist[i];
      end
    end
    if (hist.size() >= 2) begin
      fl = {val(hist[$]) == val(hist[$-1]), val(hist[$]) > val(hist[$-1]),
            val(hist[$]) < val(hist[$-1])};
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("first", 32'(first), 32'(hist.size() == 1));
    check("flags", 32'({cmp_eq, cmp_gt, cmp_lt}), 32'(fl));
    check("max_val", 32'(max_val), 32'(mx));
    check("min_val", 32'(min_val), 32'(mn));
    check("rise_cnt", 32'(rise_cnt), 32'(sat(m_rise, 255)));
    check("fall_cnt", 32'(fall_cnt), 32'(sat(m_fall, 255)));
    check("eq_cnt", 32'(eq_cnt), 32'(sat(m_eq, 255)));
    check("sat_out_valid", 32'(s_out_valid), 32'(m_valid));
    check("sat_rise_cnt", 32'(s_rise), 32'(sat(m_rise, 3)));
    check("sat_fall_cnt", 32'(s_fall), 32'(sat(m_fall, 3)));
    check("sat_eq_cnt", 32'(s_eqc), 32'(sat(m_eq, 3)));
  endfunction

  // Drive one cycle from a negedge, check in_ready, then check results at the next negedge.
  task automatic cycle(input logic cl, input logic iv, input logic [3:0] d, input logic ordy);
    logic exp_rdy;
    clear = cl;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
    exp_rdy = (!m_valid || ordy) && !cl;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    model_step(cl, iv && exp_rdy, d, ordy);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       rdy, vld, fst;
    logic [2:0] fl;
    logic [3:0] mx, mn;
    logic [7:0] rc, fc, ec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    model_reset();
    // Fields: iv, d, in_ready, out_valid, first, {eq,gt,lt}, max, min, rise, fall, eq.
    tbl[0] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'b000, 4'h0, 4'h0, 8'd0, 8'd0, 8'd0};
    tbl[1] = '{1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 3'b000, 4'h0, 4'h0, 8'd0, 8'd0, 8'd0};
    tbl[2] = '{1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 3'b100, 4'h0, 4'h0, 8'd0, 8'd0, 8'd1};
`ifdef CMP_SIGNED_EN
    tbl[3] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 3'b001, 4'h0, 4'hF, 8'd0, 8'd1, 8'd1};
    tbl[4] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 3'b100, 4'h0, 4'hF, 8'd0, 8'd1, 8'd2};
    tbl[5] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 3'b001, 4'h0, 4'hA, 8'd0, 8'd2, 8'd2};
    tbl[6] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 3'b010, 4'h5, 4'hA, 8'd1, 8'd2, 8'd2};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'b010, 4'h5, 4'hA, 8'd1, 8'd2, 8'd2};
`else
    tbl[3] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 3'b010, 4'hF, 4'h0, 8'd1, 8'd0, 8'd1};
    tbl[4] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 3'b100, 4'hF, 4'h0, 8'd1, 8'd0, 8'd2};
    tbl[5] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 3'b001, 4'hF, 4'h0, 8'd1, 8'd1, 8'd2};
    tbl[6] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 3'b001, 4'hF, 4'h0, 8'd1, 8'd2, 8'd2};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'b001, 4'hF, 4'h0, 8'd1, 8'd2, 8'd2};
`endif

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table from reset.
    for (int i = 0; i < 8; i++) begin
      clear = 1'b0;
      in_valid = tbl[i].iv;
      in_data = tbl[i].d;
      out_ready = 1'b1;
      #1;
      check("tbl_in_ready", 32'(in_ready), 32'(tbl[i].rdy));
      model_step(1'b0, tbl[i].iv && tbl[i].rdy, tbl[i].d, 1'b1);
      @(negedge clk);
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].vld));
      check("tbl_first", 32'(first), 32'(tbl[i].fst));
      check("tbl_flags", 32'({cmp_eq, cmp_gt, cmp_lt}), 32'(tbl[i].fl));
      check("tbl_max", 32'(max_val), 32'(tbl[i].mx));
      check("tbl_min", 32'(min_val), 32'(tbl[i].mn));
      check("tbl_rise", 32'(rise_cnt), 32'(tbl[i].rc));
      check("tbl_fall", 32'(fall_cnt), 32'(tbl[i].fc));
      check("tbl_eq", 32'(eq_cnt), 32'(tbl[i].ec));
    end

    // Backpressure: result held while out_ready=0, next sample waits.
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 4'h3, 1'b0);
    cycle(1'b0, 1'b1, 4'h9, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_first_held", 32'(first), 32'd1);
    check("bp_max_held", 32'(max_val), 32'h3);
    cycle(1'b0, 1'b1, 4'h9, 1'b0);
    cycle(1'b0, 1'b1, 4'h9, 1'b1);
    check("bp_second_first", 32'(first), 32'd0);
    check("bp_second_valid", 32'(out_valid), 32'd1);

    // Full-rate rising run on the CNT_W=2 instance saturates at 3.
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    for (int v = 1; v <= 5; v++) cycle(1'b0, 1'b1, 4'(v), 1'b1);
    check("sat_rise_3", 32'(s_rise), 32'd3);
    check("wide_rise_4", 32'(rise_cnt), 32'd4);

    // Clear drops a simultaneous sample; the next one starts fresh.
    cycle(1'b1, 1'b1, 4'h7, 1'b1);
    check("clr_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b1, 4'hC, 1'b1);
    check("clr_first", 32'(first), 32'd1);
    check("clr_max", 32'(max_val), 32'hC);
    check("clr_min", 32'(min_val), 32'hC);

    // Signedness corner: 7 then F.
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b0, 1'b1, 4'h7, 1'b1);
    cycle(1'b0, 1'b1, 4'hF, 1'b1);
`ifdef CMP_SIGNED_EN
    check("sgn_flags", 32'({cmp_eq, cmp_gt, cmp_lt}), 32'b001);
    check("sgn_min", 32'(min_val), 32'hF);
    check("sgn_max", 32'(max_val), 32'h7);
`else
    check("uns_flags", 32'({cmp_eq, cmp_gt, cmp_lt}), 32'b010);
    check("uns_min", 32'(min_val), 32'h7);
    check("uns_max", 32'(max_val), 32'hF);
`endif

    // Asynchronous reset while a result is pending.
    cycle(1'b0, 1'b1, 4'h2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_max", 32'(max_val), 32'd0);
    check("rst_eq_cnt", 32'(eq_cnt + rise_cnt + fall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 4'h4, 1'b1);
    check("post_rst_first", 32'(first), 32'd1);

    // Random stream.
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
            $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
